ldpc_3gpp_dec_ibuffer_nbank: RTL and testbench

- Parametrised N-bank input LLR buffer for the 3GPP LDPC decoder, sitting between the input LLR loader and the decoder core.
- Holds 2**pBNUM_W code blocks: data-column RAMs, parity-row RAMs and a per-bank tag.
- Bank ring control is built in; no external slogic instance.
- Writes are gated when no bank is free, and an occupancy count is exported.

---
 rtl/ldpc_3gpp_dec_ibuffer_nbank_if.sv | 68 ++++++
 rtl/ldpc_3gpp_dec_ibuffer_nbank.sv | 214 +++++++++++++++++++++
 tb/tb_ldpc_3gpp_dec_ibuffer_nbank.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_3gpp_dec_ibuffer_nbank_if.sv
// LDPC 3GPP decoder input buffer: loader/core-side bus bundle.
// Optional error outputs are present when LDPC_3GPP_DEC_IBUFFER_ERR_EN is defined.
interface ldpc_3gpp_dec_ibuffer_nbank_if #(
  parameter int pBNUM_W       = 1,
  parameter int pCOL_BY_CYCLE = 22,
  parameter int pROW_BY_CYCLE = 1,
  parameter int pLLR_BY_CYCLE = 8,
  parameter int pLLR_W        = 5,
  parameter int pP_ADDR_W     = 8,
  parameter int pTAG_W        = 8
);
  localparam int WW = pLLR_BY_CYCLE * pLLR_W;

  logic                             iclkena;
  logic [pCOL_BY_CYCLE-1:0]         iwrite;
  logic [1:0]                       iclear;
  logic [pROW_BY_CYCLE-1:0]         ipwrite;
  logic [pROW_BY_CYCLE-1:0]         ipclear;
  logic                             iwfull;
  logic [pP_ADDR_W-1:0]             iwaddr;
  logic [WW-1:0]                    iLLR;
  logic [pTAG_W-1:0]                iwtag;
  logic                             irempty;
  logic [pP_ADDR_W-1:0]             iraddr;
  logic [pCOL_BY_CYCLE*WW-1:0]      oLLR;
  logic [pROW_BY_CYCLE*WW-1:0]      opLLR;
  logic [pTAG_W-1:0]                ortag;
  logic [pBNUM_W-1:0]               owbank;
  logic [pBNUM_W-1:0]               orbank;
  logic [pBNUM_W:0]                 oused;
  logic                             oempty;
  logic                             oemptya;
  logic                             ofull;
  logic                             ofulla;

`ifdef LDPC_3GPP_DEC_IBUFFER_ERR_EN
  logic                             owerr;
  logic [15:0]                      owdrop;

  modport master (
    output iclkena, iwrite, iclear, ipwrite, ipclear,
    output iwfull, iwaddr, iLLR, iwtag, irempty, iraddr,
    input  oLLR, opLLR, ortag, owbank, orbank, oused,
    input  oempty, oemptya, ofull, ofulla, owerr, owdrop
  );

  modport slave (
    input  iclkena, iwrite, iclear, ipwrite, ipclear,
    input  iwfull, iwaddr, iLLR, iwtag, irempty, iraddr,
    output oLLR, opLLR, ortag, owbank, orbank, oused,
    output oempty, oemptya, ofull, ofulla, owerr, owdrop
  );
`else
  modport master (
    output iclkena, iwrite, iclear, ipwrite, ipclear,
    output iwfull, iwaddr, iLLR, iwtag, irempty, iraddr,
    input  oLLR, opLLR, ortag, owbank, orbank, oused,
    input  oempty, oemptya, ofull, ofulla
  );

  modport slave (
    input  iclkena, iwrite, iclear, ipwrite, ipclear,
    input  iwfull, iwaddr, iLLR, iwtag, irempty, iraddr,
    output oLLR, opLLR, ortag, owbank, orbank, oused,
    output oempty, oemptya, ofull, ofulla
  );
`endif
endinterface

// File: rtl/ldpc_3gpp_dec_ibuffer_nbank.sv
// N-bank input LLR buffer with built-in bank ring control.
// Define LDPC_3GPP_DEC_IBUFFER_ERR_EN to add owerr/owdrop drop reporting.
module ldpc_3gpp_dec_ibuffer_nbank #(
  parameter int pBNUM_W       = 1,
  parameter int pIDX_GR       = 0,
  parameter int pCODE         = 4,
  parameter int pDO_PUNCT     = 0,
  parameter int pCOL_BY_CYCLE = 22,
  parameter int pROW_BY_CYCLE = 1,
  parameter int pLLR_BY_CYCLE = 8,
  parameter int pLLR_W        = 5,
  parameter int pD_ADDR_W     = 8,
  parameter int pP_ADDR_W     = 8,
  parameter int pTAG_W        = 8
) (
  input logic iclk,
  input logic ireset,
  ldpc_3gpp_dec_ibuffer_nbank_if.slave bus
);

  localparam int NB  = 1 << pBNUM_W;
  localparam int WW  = pLLR_BY_CYCLE * pLLR_W;
  localparam int DAW = pBNUM_W + pD_ADDR_W;
  localparam int PAW = pBNUM_W + pP_ADDR_W;
  localparam logic [pBNUM_W:0] CNT_MAX = (pBNUM_W+1)'(NB);
  localparam bit PAR_ON = (pCODE >= 4);

  function automatic bit col_on(int c);
    return !((pIDX_GR == 1 && c >= 14) ||
             (pDO_PUNCT == 1 && c < 2));
  endfunction

  logic [pBNUM_W-1:0] wp;
  logic [pBNUM_W-1:0] rp;
  logic [pBNUM_W:0]   cnt;
  logic [pBNUM_W:0]   cnt_nxt;
  logic [pBNUM_W:0]   used;
  logic               f_empty;
  logic               f_emptya;
  logic               f_full;
  logic               f_fulla;
  logic               not_full;
  logic               not_empty;
  logic               wa;
  logic               ra;
  logic               wr_ok;

  logic [pBNUM_W-1:0]   rbank;
  logic [pP_ADDR_W-1:0] raddr;
  logic [DAW-1:0]       wdaddr;
  logic [DAW-1:0]       rdaddr;
  logic [PAW-1:0]       wpaddr;
  logic [PAW-1:0]       rpaddr;

  logic [pCOL_BY_CYCLE*WW-1:0] d_rd;
  logic [pROW_BY_CYCLE*WW-1:0] p_rd;

  logic [pTAG_W-1:0] tram [NB];

  assign not_full  = (cnt != CNT_MAX);
  assign not_empty = (cnt != '0);
  assign wa        = bus.iwfull & not_full;
  assign ra        = bus.irempty & not_empty;
  assign wr_ok     = bus.iclkena & not_full;

  // occupancy next state from accepted close/release
  always_comb begin
    cnt_nxt = cnt;
    unique case ({wa, ra})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // bank ring pointers, count and registered flags
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      used     <= '0;
      f_empty  <= 1'b1;
      f_emptya <= 1'b1;
      f_full   <= 1'b0;
      f_fulla  <= 1'b0;
    end else if (bus.iclkena) begin
      if (wa) wp <= wp + 1'b1;
      if (ra) rp <= rp + 1'b1;
      cnt      <= cnt_nxt;
      used     <= cnt_nxt;
      f_empty  <= (cnt_nxt != CNT_MAX);
      f_emptya <= (cnt_nxt == '0);
      f_full   <= (cnt_nxt != '0);
      f_fulla  <= (cnt_nxt == CNT_MAX);
    end
  end

  // block tag latched into the closing bank
  always_ff @(posedge iclk) begin
    if (bus.iclkena && wa) tram[wp] <= bus.iwtag;
  end

  // read address stage: bank travels with the address
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      rbank <= '0;
      raddr <= '0;
    end else if (bus.iclkena) begin
      rbank <= rp;
      raddr <= bus.iraddr;
    end
  end

  assign wdaddr = {wp, bus.iwaddr[pD_ADDR_W-1:0]};
  assign wpaddr = {wp, bus.iwaddr};
  assign rdaddr = {rbank, raddr[pD_ADDR_W-1:0]};
  assign rpaddr = {rbank, raddr};

  for (genvar c = 0; c < pCOL_BY_CYCLE; c++) begin : g_col
    if (col_on(c)) begin : g_ram
      logic [WW-1:0] mem [2**DAW];
      logic [WW-1:0] dout;
      logic [WW-1:0] wdat;

      if (c < 2) begin : g_clr
        assign wdat = bus.iclear[c] ? '0 : bus.iLLR;
      end else begin : g_pass
        assign wdat = bus.iLLR;
      end

      // data column write port
      always_ff @(posedge iclk) begin
        if (wr_ok && bus.iwrite[c]) mem[wdaddr] <= wdat;
      end

      // data column registered read
      always_ff @(posedge iclk) begin
        if (bus.iclkena) dout <= mem[rdaddr];
      end

      assign d_rd[c*WW +: WW] = dout;
    end else begin : g_nul
      assign d_rd[c*WW +: WW] = '0;
    end
  end

  for (genvar r = 0; r < pROW_BY_CYCLE; r++) begin : g_row
    if (PAR_ON && r < pCODE) begin : g_ram
      logic [WW-1:0] mem [2**PAW];
      logic [WW-1:0] dout;
      logic [WW-1:0] wdat;

      assign wdat = bus.ipclear[r] ? '0 : bus.iLLR;

      // parity row write port
      always_ff @(posedge iclk) begin
        if (wr_ok && bus.ipwrite[r]) mem[wpaddr] <= wdat;
      end

      // parity row registered read
      always_ff @(posedge iclk) begin
        if (bus.iclkena) dout <= mem[rpaddr];
      end

      assign p_rd[r*WW +: WW] = dout;
    end else begin : g_nul
      assign p_rd[r*WW +: WW] = '0;
    end
  end

  assign bus.oLLR    = d_rd;
  assign bus.opLLR   = p_rd;
  assign bus.ortag   = tram[rp];
  assign bus.owbank  = wp;
  assign bus.orbank  = rp;
  assign bus.oused   = used;
  assign bus.oempty  = f_empty;
  assign bus.oemptya = f_emptya;
  assign bus.ofull   = f_full;
  assign bus.ofulla  = f_fulla;

`ifdef LDPC_3GPP_DEC_IBUFFER_ERR_EN
  logic        drop;
  logic        err_set;
  logic        werr;
  logic [15:0] wdrop;

  assign drop = bus.iclkena & ~not_full &
                ((|bus.iwrite) | (|bus.ipwrite));
  assign err_set = drop | (bus.iclkena &
                   ((bus.iwfull & ~not_full) |
                    (bus.irempty & ~not_empty)));

  // sticky error flag and saturating drop counter
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      werr  <= 1'b0;
      wdrop <= '0;
    end else begin
      if (err_set) werr <= 1'b1;
      if (drop && wdrop != 16'hFFFF) wdrop <= wdrop + 1'b1;
    end
  end

  assign bus.owerr  = werr;
  assign bus.owdrop = wdrop;
`endif

  logic unused_ok;
  assign unused_ok = ^{bus.iwrite, bus.iclear, bus.ipclear,
                       bus.ipwrite, bus.iwaddr, raddr};

endmodule

// File: tb/tb_ldpc_3gpp_dec_ibuffer_nbank.sv
// Directed plus randomized bench for the N-bank LLR input buffer.
// Reference model tracks banks, tags and contents as plain arrays.
module tb_ldpc_3gpp_dec_ibuffer_nbank;

  localparam int BW  = 2;
  localparam int NB  = 4;
  localparam int COL = 22;
  localparam int ROW = 1;
  localparam int LBC = 8;
  localparam int LW  = 5;
  localparam int WW  = LBC * LW;
  localparam int DAW = 4;
  localparam int PAW = 5;
  localparam int TW  = 8;
  localparam logic [WW-1:0] F15 = {LBC{5'h0F}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ldpc_3gpp_dec_ibuffer_nbank_if #(
    .pBNUM_W(BW), .pCOL_BY_CYCLE(COL), .pROW_BY_CYCLE(ROW),
    .pLLR_BY_CYCLE(LBC), .pLLR_W(LW), .pP_ADDR_W(PAW),
    .pTAG_W(TW)
  ) bus ();

  ldpc_3gpp_dec_ibuffer_nbank #(
    .pBNUM_W(BW), .pIDX_GR(1), .pCODE(4), .pDO_PUNCT(0),
    .pCOL_BY_CYCLE(COL), .pROW_BY_CYCLE(ROW),
    .pLLR_BY_CYCLE(LBC), .pLLR_W(LW), .pD_ADDR_W(DAW),
    .pP_ADDR_W(PAW), .pTAG_W(TW)
  ) dut (
    .iclk(clk),
    .ireset(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [WW-1:0] dm [NB][16][COL];
  logic [WW-1:0] pm [NB][32];
  logic [TW-1:0] tm [NB];
  bit            tv [NB];
  int            m_wp, m_rp, m_cnt, m_drop;
  bit            m_err;

  task automatic chk(string tg, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  function automatic bit col_on(int c);
    return c < 14;
  endfunction

  function automatic logic [WW-1:0] rnd_word();
    return WW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [WW-1:0] exp_col(int b, int a, int c);
    return col_on(c) ? dm[b][a % 16][c] : '0;
  endfunction

  task automatic idle();
    bus.iclkena = 1'b1;
    bus.iwrite  = '0;
    bus.iclear  = '0;
    bus.ipwrite = '0;
    bus.ipclear = '0;
    bus.iwfull  = 1'b0;
    bus.iwaddr  = '0;
    bus.iLLR    = '0;
    bus.iwtag   = '0;
    bus.irempty = 1'b0;
  endtask

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_cnt = 0;
    m_drop = 0; m_err = 1'b0;
  endtask

  task automatic model_update();
    bit full, empty, wany;
    int a;
    full  = (m_cnt == NB);
    empty = (m_cnt == 0);
    wany  = (|bus.iwrite) || (|bus.ipwrite);
    a     = int'(bus.iwaddr);
    if (!full) begin
      for (int c = 0; c < COL; c++)
        if (bus.iwrite[c])
          dm[m_wp][a % 16][c] =
            (c < 2 && bus.iclear[c]) ? '0 : bus.iLLR;
      if (bus.ipwrite[0])
        pm[m_wp][a] = bus.ipclear[0] ? '0 : bus.iLLR;
    end else if (wany) begin
      m_err = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    if (bus.iwfull && full) m_err = 1'b1;
    if (bus.irempty && empty) m_err = 1'b1;
    if (bus.iwfull && !full) begin
      tm[m_wp] = bus.iwtag;
      tv[m_wp] = 1'b1;
      m_wp = (m_wp + 1) % NB;
      m_cnt++;
    end
    if (bus.irempty && !empty) begin
      m_rp = (m_rp + 1) % NB;
      m_cnt--;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && bus.iclkena) model_update();
    @(negedge clk);
  endtask

  task automatic check_status(string tg);
    chk({tg, ":oused"},   64'(bus.oused),   64'(m_cnt));
    chk({tg, ":oempty"},  64'(bus.oempty),  64'(m_cnt != NB));
    chk({tg, ":oemptya"}, 64'(bus.oemptya), 64'(m_cnt == 0));
    chk({tg, ":ofull"},   64'(bus.ofull),   64'(m_cnt != 0));
    chk({tg, ":ofulla"},  64'(bus.ofulla),  64'(m_cnt == NB));
    chk({tg, ":owbank"},  64'(bus.owbank),  64'(m_wp));
    chk({tg, ":orbank"},  64'(bus.orbank),  64'(m_rp));
    if (tv[m_rp])
      chk({tg, ":ortag"}, 64'(bus.ortag),   64'(tm[m_rp]));
`ifdef LDPC_3GPP_DEC_IBUFFER_ERR_EN
    chk({tg, ":owerr"},   64'(bus.owerr),   64'(m_err));
    chk({tg, ":owdrop"},  64'(bus.owdrop),  64'(m_drop));
`endif
  endtask

  task automatic read_chk(string tg, int a0, int n);
    int b;
    b = m_rp;
    idle();
    for (int j = 0; j <= n; j++) begin
      if (j < n) bus.iraddr = PAW'(a0 + j);
      step();
      if (j >= 1) begin
        for (int c = 0; c < COL; c++)
          chk($sformatf("%s_b%0d_a%0d_c%0d", tg, b, a0+j-1, c),
              64'(bus.oLLR[c*WW +: WW]),
              64'(exp_col(b, a0 + j - 1, c)));
        chk($sformatf("%s_b%0d_a%0d_par", tg, b, a0+j-1),
            64'(bus.opLLR[0 +: WW]), 64'(pm[b][a0 + j - 1]));
      end
    end
  endtask

  task automatic write_word(int a);
    bus.iwaddr  = PAW'(a);
    bus.iwrite  = '1;
    bus.ipwrite = '1;
    bus.iLLR    = rnd_word();
  endtask

  initial begin
    for (int b = 0; b < NB; b++) tv[b] = 1'b0;
    model_reset();
    idle();
    bus.iraddr = '0;

    repeat (3) @(negedge clk);
    check_status("reset");
    rst_n = 1'b1;
    step();
    check_status("post_reset");

    for (int a = 0; a < 4; a++) begin
      idle(); write_word(a); step();
    end
    idle(); write_word(4);
    bus.iwfull = 1'b1; bus.iwtag = 8'hA5;
    step();
    idle();
    check_status("fill0");
    read_chk("rd0", 0, 5);

    for (int t = 2; t <= 4; t++) begin
      idle(); write_word(0);
      bus.iwfull = 1'b1; bus.iwtag = TW'(t);
      step();
    end
    idle();
    check_status("allfull");

    idle(); write_word(0);
    bus.iwfull = 1'b1; bus.iwtag = 8'h05;
    step();
    idle(); write_word(1); step();
    idle();
    check_status("dropped");
    read_chk("rd0_intact", 0, 5);

    idle(); bus.irempty = 1'b1; step();
    idle(); bus.irempty = 1'b1; step();
    idle();
    check_status("rel2");

    for (int k = 0; k < 3; k++) begin
      idle();
      bus.iwfull = 1'b1; bus.irempty = 1'b1;
      bus.iwtag = TW'(8'h60 + k);
      step();
      idle();
      check_status($sformatf("both%0d", k));
    end

    idle(); bus.irempty = 1'b1; step();
    idle(); bus.irempty = 1'b1; step();
    idle(); bus.irempty = 1'b1; step();
    idle();
    check_status("drained");

    idle(); write_word(5);
    bus.iLLR    = F15;
    bus.iclear  = 2'b11;
    bus.ipclear = 1'b1;
    bus.iwfull  = 1'b1;
    bus.iwtag   = 8'h3C;
    step();
    idle();
    check_status("clr_close");
    read_chk("rd_clr", 5, 1);
    chk("clr_col0",  64'(bus.oLLR[0*WW +: WW]),  64'(0));
    chk("clr_col1",  64'(bus.oLLR[1*WW +: WW]),  64'(0));
    chk("clr_col2",  64'(bus.oLLR[2*WW +: WW]),  64'(F15));
    chk("clr_col13", 64'(bus.oLLR[13*WW +: WW]), 64'(F15));
    chk("clr_col14", 64'(bus.oLLR[14*WW +: WW]), 64'(0));
    chk("clr_par0",  64'(bus.opLLR[0 +: WW]),    64'(0));

    idle();
    bus.iclkena = 1'b0;
    bus.iwfull  = 1'b1;
    bus.irempty = 1'b1;
    bus.iwtag   = 8'hEE;
    step();
    step();
    idle();
    check_status("clkena_off");

    for (int i = 0; i < 400; i++) begin
      idle();
      bus.iclkena = ($urandom_range(0, 9) != 0);
      bus.iwfull  = ($urandom_range(0, 2) == 0);
      bus.irempty = ($urandom_range(0, 2) == 0);
      bus.iwtag   = TW'($urandom());
      bus.iraddr  = PAW'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        bus.iwrite  = COL'({$urandom(), $urandom()});
        bus.ipwrite = ROW'($urandom());
        bus.iclear  = 2'($urandom());
        bus.ipclear = ROW'($urandom());
        bus.iwaddr  = PAW'($urandom());
        bus.iLLR    = rnd_word();
      end
      step();
      check_status("rnd");
    end

    idle();
    for (int i = 0; i < 12 && m_cnt != 3; i++) begin
      idle();
      if (m_cnt < 3) bus.iwfull = 1'b1;
      else bus.irempty = 1'b1;
      bus.iwtag = TW'($urandom());
      step();
    end
    idle();
    check_status("pre_rst");
    chk("pre_rst_used3", 64'(bus.oused), 64'(3));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status("rst_async");
    step();
    check_status("rst_hold");
    rst_n = 1'b1;
    step();
    check_status("rst_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
